mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: CYCLES, 32, number of iteration cycles in RUN; fixed at 32 for the 32-bit datapath.
REQ-002 Port: Clk, input, 1, single clock; all state updates occur on its rising edge.
REQ-003 Port: Resetn, input, 1, reset; asynchronous and active-low.
REQ-004 Port: BusA, input, 32, rs operand from the register file; multiplicand or dividend.
REQ-005 Port: BusB, input, 32, rt operand from the register file; multiplier or divisor.
REQ-006 Port: Op, input, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Port: Start, input, 1, launch request, sampled only while Busy=0.
REQ-008 Port: HiWr, input, 1, MTHI request; loads BusW into Hi.
REQ-009 Port: LoWr, input, 1, MTLO request; loads BusW into Lo.
REQ-010 Port: BusW, input, 32, data for MTHI/MTLO.
REQ-011 Port: Busy, output, 1, high while an operation is in flight; the pipeline stalls on it.
REQ-012 Port: Done, output, 1, registered pulse, one cycle wide, flagging a new Hi/Lo result.
REQ-013 Port: Hi, output, 32, HI register: product[63:32] or remainder.
REQ-014 Port: Lo, output, 32, LO register: product[31:0] or quotient.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and FINISH; Busy SHALL be high whenever the state is not IDLE.
- IDLE to RUN: on an edge with Start=1.
- RUN to FINISH: on the edge completing iteration CYCLES-1.
- FINISH to IDLE: always, on the next edge.
REQ-016 On the Start edge the block SHALL latch Op, sign flags and operand magnitudes, and SHALL clear the 6-bit iteration counter.
- Signed ops (MULT, DIV) latch absolute values.
- Unsigned ops latch the raw values.
REQ-017 Each RUN edge SHALL perform exactly one step: a shift-add for multiply, or a restoring subtract-shift for divide.
REQ-018 On the FINISH to IDLE edge the block SHALL apply sign fixup, write Hi and Lo, and set Done=1 for exactly one cycle.
REQ-019 Latency SHALL be 33 edges from the Start edge E0 to the Hi/Lo update edge E33, with Busy high during cycles E0+ through E33-.
REQ-020 Multiply results SHALL be exact 64-bit products: MULT two's-complement, MULTU unsigned.
REQ-021 Divide quotients SHALL truncate toward zero, and the remainder sign SHALL follow the dividend.
REQ-022 Divide by zero (BusB=0, DIV or DIVU) SHALL give Lo=32'hFFFFFFFF and Hi=BusA as latched, at the normal latency.
REQ-023 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give Lo=32'h80000000 and Hi=0.
REQ-024 Start while Busy=1 SHALL be ignored, and operands SHALL NOT be re-latched.
REQ-025 HiWr and LoWr SHALL take effect only in IDLE with Start=0; otherwise they are dropped.
- HiWr and LoWr may be asserted together; both registers update.
- If Start=1 on the same edge, Start wins.
REQ-026 Hi and Lo SHALL be unaffected during RUN and FINISH, so reads during Busy return the previous values.

Reset
REQ-027 Resetn=0 SHALL immediately force:
- state IDLE and counter 0;
- Busy=0 and Done=0;
- Hi=32'h0 and Lo=32'h0;
- all internal operand registers to 0.
REQ-028 Reset asserted mid-operation SHALL abort it, and no partial result SHALL ever reach Hi or Lo.
REQ-029 After Resetn rises, the first rising Clk edge SHALL sample Start normally.

Configuration
REQ-030 The macro MULTDIV_FAST_MUL_EN SHALL select the multiply implementation.
- Defined: MULT and MULTU compute the product combinationally; IDLE goes directly to FINISH, so Hi/Lo update on edge E1 and Busy is high for one cycle.
- Undefined: multiply uses the iterative 33-edge path.
- Divide SHALL take 33 edges in both builds.

Verification
REQ-031 MULTU BusA=32'hFFFFFFFF, BusB=32'hFFFFFFFF -> after 33 edges Hi=32'hFFFFFFFE, Lo=32'h00000001, Done pulses once.
REQ-032 MULT BusA=-7 (32'hFFFFFFF9), BusB=3 -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB (-21).
REQ-033 DIV BusA=-7, BusB=2 -> Lo=32'hFFFFFFFD (-3), Hi=32'hFFFFFFFF (-1); DIVU 100/0 -> Lo=32'hFFFFFFFF, Hi=100.
REQ-034 Start DIVU 10/3, then at edge E5 pulse Start with new operands and HiWr=1 with BusW=32'h55 -> both ignored; at E33 Hi=1, Lo=3.
REQ-035 Start MULTU, drop Resetn at E10 for half a cycle -> Busy=0, Done=0, Hi=Lo=0 immediately, with no Done pulse afterwards.
REQ-036 With MULTDIV_FAST_MUL_EN defined, MULTU 6*7 -> Lo=42, Hi=0 at edge E1; in the same build, DIV 42/6 still completes at E33 with Lo=7.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if -- bus between the pipeline and the multiply/divide unit.
//
//   BusA  : rs operand (multiplicand / dividend)
//   BusB  : rt operand (multiplier / divisor)
//   Op    : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   Start : launch request, honoured only while Busy=0
//   HiWr  : MTHI request, loads BusW into Hi
//   LoWr  : MTLO request, loads BusW into Lo
//   BusW  : data for MTHI/MTLO
//   Busy  : operation in flight (pipeline stall)
//   Done  : one-cycle pulse when Hi/Lo receive a new result
//   Hi/Lo : HI and LO registers
//
// master = pipeline side, slave = mult_div_unit side.
// -----------------------------------------------------------------------------
interface mult_div_unit_if;
   logic [31:0] BusA;
   logic [31:0] BusB;
   logic [1:0]  Op;
   logic        Start;
   logic        HiWr;
   logic        LoWr;
   logic [31:0] BusW;
   logic        Busy;
   logic        Done;
   logic [31:0] Hi;
   logic [31:0] Lo;

   modport master (
      output BusA, BusB, Op, Start, HiWr, LoWr, BusW,
      input  Busy, Done, Hi, Lo
   );

   modport slave (
      input  BusA, BusB, Op, Start, HiWr, LoWr, BusW,
      output Busy, Done, Hi, Lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit -- MIPS-style HI/LO multiply/divide unit.
//
// Ports:
//   Clk    : clock, rising edge
//   Resetn : asynchronous active-low reset
//   bus    : mult_div_unit_if.slave (operands, Op, Start, MTHI/MTLO, Busy,
//            Done, Hi, Lo)
//
// Operation: on a Start edge operand magnitudes are latched; RUN performs
// CYCLES (32) shift-add (multiply) or restoring subtract-shift (divide)
// steps; FINISH applies the sign fixup and writes Hi/Lo with a Done pulse.
// Start-to-result latency is 33 edges.
//
// Build option:
//   MULTDIV_FAST_MUL_EN : when defined, MULT/MULTU compute the product
//                         combinationally and go IDLE -> FINISH, so the
//                         result lands one edge after Start. Divide is
//                         always iterative.
// -----------------------------------------------------------------------------
module mult_div_unit #(
   parameter int unsigned CYCLES = 32
) (
   input logic             Clk,
   input logic             Resetn,
   mult_div_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic [1:0]  op_q;
   logic        sign_a_q, sign_b_q;   // raw operand sign bits
   logic [31:0] opb_q;                // multiplicand or divisor magnitude
   logic [63:0] acc_q;                // mul: {partial, multiplier}; div: {rem, quot}
   logic        busy_q, done_q;
   logic [31:0] hi_q, lo_q;

   // Start-time operand magnitudes (signed ops use absolute values)
   logic        neg_a_in, neg_b_in;
   logic [31:0] mag_a, mag_b;

   // Iteration step and result fixup
   logic        is_div, neg_a, neg_b, div_zero;
   logic [32:0] mul_sum, div_shift, div_diff;
   logic [63:0] step_d, prod_fix;
   logic [31:0] quot_fix, rem_fix;
   logic [31:0] res_hi_d, res_lo_d;

   always_comb begin
      neg_a_in = ~bus.Op[0] & bus.BusA[31];
      neg_b_in = ~bus.Op[0] & bus.BusB[31];
      mag_a    = neg_a_in ? (32'd0 - bus.BusA) : bus.BusA;
      mag_b    = neg_b_in ? (32'd0 - bus.BusB) : bus.BusB;
   end

   always_comb begin
      is_div   = op_q[1];
      neg_a    = ~op_q[0] & sign_a_q;
      neg_b    = ~op_q[0] & sign_b_q;
      div_zero = (opb_q == '0);

      // Multiply: add multiplicand into the upper half when the current
      // multiplier bit is set, then shift the 65-bit {carry, acc} right.
      mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);

      // Divide: shift the next dividend bit (quotient MSB) into the
      // remainder and try subtracting the divisor; restore on borrow.
      div_shift = {acc_q[63:32], acc_q[31]};
      div_diff  = div_shift - {1'b0, opb_q};

      if (is_div) begin
         if (div_diff[32])
            step_d = {div_shift[31:0], acc_q[30:0], 1'b0};
         else
            step_d = {div_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
         step_d = {mul_sum, acc_q[31:1]};
      end

      prod_fix = (neg_a ^ neg_b) ? (64'd0 - acc_q) : acc_q;
      quot_fix = (neg_a ^ neg_b) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      // Remainder follows the dividend; with a zero divisor the remainder
      // is the dividend magnitude, so this restores BusA as latched.
      rem_fix  = neg_a ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

      if (is_div) begin
         res_hi_d = rem_fix;
         res_lo_d = div_zero ? '1 : quot_fix;
      end else begin
         res_hi_d = prod_fix[63:32];
         res_lo_d = prod_fix[31:0];
      end
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         opb_q    <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.Start) begin
                  op_q     <= bus.Op;
                  sign_a_q <= bus.BusA[31];
                  sign_b_q <= bus.BusB[31];
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
`ifdef MULTDIV_FAST_MUL_EN
                  if (!bus.Op[1]) begin
                     opb_q   <= mag_a;
                     acc_q   <= 64'(mag_a) * 64'(mag_b);
                     state_q <= FINISH;
                  end else begin
                     opb_q   <= mag_b;
                     acc_q   <= {32'd0, mag_a};
                     state_q <= RUN;
                  end
`else
                  opb_q   <= bus.Op[1] ? mag_b : mag_a;
                  acc_q   <= {32'd0, bus.Op[1] ? mag_a : mag_b};
                  state_q <= RUN;
`endif
               end else begin
                  if (bus.HiWr) hi_q <= bus.BusW;
                  if (bus.LoWr) lo_q <= bus.BusW;
               end
            end
            RUN: begin
               acc_q <= step_d;
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == 6'(CYCLES - 1)) state_q <= FINISH;
            end
            FINISH: begin
               hi_q    <= res_hi_d;
               lo_q    <= res_lo_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.Busy = busy_q;
   assign bus.Done = done_q;
   assign bus.Hi   = hi_q;
   assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit -- self-checking bench for mult_div_unit.
// Reference results come from plain 64-bit arithmetic on the operands.
// Honours MULTDIV_FAST_MUL_EN for the expected multiply latency.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

   logic Clk = 1'b0;
   logic Resetn;
   always #5 Clk = ~Clk;

   mult_div_unit_if bus ();

   mult_div_unit #(.CYCLES(32)) dut (
      .Clk    (Clk),
      .Resetn (Resetn),
      .bus    (bus.slave)
   );

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [31:0] exp_hi, exp_lo;

   task automatic check_eq(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns {Hi, Lo}
   function automatic logic [63:0] ref_model(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         2'b00: r = sa * sb;
         2'b01: r = ua * ub;
         2'b10: begin
            if (b == 32'd0) r = {a, 32'hFFFFFFFF};
            else begin
               sq = sa / sb;
               sr = sa % sb;
               r  = {sr[31:0], sq[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) r = {a, 32'hFFFFFFFF};
            else begin
               uq = ua / ub;
               ur = ua % ub;
               r  = {ur[31:0], uq[31:0]};
            end
         end
      endcase
      return r;
   endfunction

   function automatic int latency(input logic [1:0] op);
`ifdef MULTDIV_FAST_MUL_EN
      return op[1] ? 33 : 1;
`else
      return 33;
`endif
   endfunction

   // Entered just after a falling edge with the bus idle. disturb_at > 0
   // presents Start + HiWr for the edge E<disturb_at>, which must be ignored.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int disturb_at);
      logic [63:0] e;
      int          lat;
      e   = ref_model(op, a, b);
      lat = latency(op);
      bus.Op = op; bus.BusA = a; bus.BusB = b; bus.Start = 1'b1;
      @(posedge Clk);                       // E0
      @(negedge Clk);
      bus.Start = 1'b0; bus.HiWr = 1'b0; bus.LoWr = 1'b0;
      bus.BusA = $urandom; bus.BusB = $urandom;  // operands must be latched
      check_eq("busy_e0", {63'd0, bus.Busy}, 64'd1);
      check_eq("done_e0", {63'd0, bus.Done}, 64'd0);
      check_eq("hi_hold_e0", {32'd0, bus.Hi}, {32'd0, exp_hi});
      for (int k = 1; k <= lat; k++) begin
         if (k == disturb_at) begin
            bus.Start = 1'b1; bus.Op = 2'($urandom);
            bus.HiWr = 1'b1; bus.BusW = 32'h55;
         end
         @(posedge Clk);
         @(negedge Clk);
         if (k == disturb_at) begin
            bus.Start = 1'b0; bus.HiWr = 1'b0;
            check_eq("hi_hold_disturb", {32'd0, bus.Hi}, {32'd0, exp_hi});
         end
         if (k == lat - 1) begin
            check_eq("busy_last", {63'd0, bus.Busy}, 64'd1);
            check_eq("done_early", {63'd0, bus.Done}, 64'd0);
            check_eq("lo_hold", {32'd0, bus.Lo}, {32'd0, exp_lo});
         end
      end
      check_eq("done_pulse", {63'd0, bus.Done}, 64'd1);
      check_eq("busy_clear", {63'd0, bus.Busy}, 64'd0);
      check_eq("result", {bus.Hi, bus.Lo}, e);
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      @(posedge Clk);
      @(negedge Clk);
      check_eq("done_width", {63'd0, bus.Done}, 64'd0);
   endtask

   task automatic mt_write(input logic hw, input logic lw, input logic [31:0] w);
      bus.HiWr = hw; bus.LoWr = lw; bus.BusW = w;
      @(posedge Clk);
      @(negedge Clk);
      bus.HiWr = 1'b0; bus.LoWr = 1'b0;
      if (hw) exp_hi = w;
      if (lw) exp_lo = w;
      check_eq("mt_hi", {32'd0, bus.Hi}, {32'd0, exp_hi});
      check_eq("mt_lo", {32'd0, bus.Lo}, {32'd0, exp_lo});
   endtask

   initial begin
      int          pulses;
      logic [1:0]  op;
      logic [31:0] a, b;

      Resetn = 1'b0;
      bus.BusA = '0; bus.BusB = '0; bus.Op = '0; bus.Start = 1'b0;
      bus.HiWr = 1'b0; bus.LoWr = 1'b0; bus.BusW = '0;
      exp_hi = '0; exp_lo = '0;
      #12;
      check_eq("rst_busy", {63'd0, bus.Busy}, 64'd0);
      check_eq("rst_done", {63'd0, bus.Done}, 64'd0);
      check_eq("rst_hilo", {bus.Hi, bus.Lo}, 64'd0);
      @(negedge Clk);
      Resetn = 1'b1;

      // Directed cases
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      run_op(2'b00, 32'hFFFFFFF9, 32'd3, 0);
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
      run_op(2'b11, 32'd100, 32'd0, 0);
      run_op(2'b10, 32'hFFFFFF9C, 32'd0, 0);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
      run_op(2'b00, 32'h80000000, 32'h80000000, 0);
      run_op(2'b01, 32'd6, 32'd7, 0);
      run_op(2'b11, 32'd42, 32'd6, 0);
      run_op(2'b11, 32'd10, 32'd3, 5);

      // MTHI/MTLO, separately and together
      mt_write(1'b1, 1'b0, 32'hA5A5_0001);
      mt_write(1'b0, 1'b1, 32'h0000_5A5A);
      mt_write(1'b1, 1'b1, 32'hDEAD_BEEF);

      // Start on the same edge as HiWr/LoWr: Start wins
      bus.HiWr = 1'b1; bus.LoWr = 1'b1; bus.BusW = 32'h55;
      run_op(2'b10, 32'd1000, 32'hFFFFFFF9, 0);

      // Randomised operations
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom);
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 3))
            0: ;
            1: begin a = 32'($signed(4'($urandom))); b = 32'($urandom_range(0, 15)); end
            2: b = 32'd0;
            default: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         endcase
         run_op(op, a, b, 0);
      end

      // Reset mid-operation
      mt_write(1'b1, 1'b1, 32'h1234_5678);
      bus.Op = 2'b01; bus.BusA = $urandom; bus.BusB = $urandom; bus.Start = 1'b1;
      @(posedge Clk);                       // E0
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (10) @(posedge Clk);           // E10
      #1 Resetn = 1'b0;
      #2;
      check_eq("abort_busy", {63'd0, bus.Busy}, 64'd0);
      check_eq("abort_done", {63'd0, bus.Done}, 64'd0);
      check_eq("abort_hilo", {bus.Hi, bus.Lo}, 64'd0);
      @(negedge Clk);
      Resetn = 1'b1;
      exp_hi = '0; exp_lo = '0;
      pulses = 0;
      repeat (40) begin
         @(negedge Clk);
         if (bus.Done) pulses++;
      end
      check_eq("abort_no_done", 64'(pulses), 64'd0);
      check_eq("abort_hilo_after", {bus.Hi, bus.Lo}, 64'd0);

      // First edge after reset release samples Start
      @(negedge Clk);
      Resetn = 1'b0;
      #2 Resetn = 1'b1;
      run_op(2'b11, 32'd77, 32'd5, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
